biu_arbiter: RTL and testbench
==============================

BIU_ARBITER -- requirements
Module: biu_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of every master and the slave port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width of every master and the slave port.
REQ-003 SHALL have parameter NUM_MASTERS, default 4, legal range 2..16: number of BIU master channels.
REQ-004 SHALL have parameter TIMEOUT, default 255: number of WAIT cycles before forced completion; 0 disables the timeout.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port m_address, input, NUM_MASTERS*ADDR_WIDTH bits: per-master address, master i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port m_data_out, input, NUM_MASTERS*DATA_WIDTH bits: per-master write data, sliced as in REQ-007.
REQ-009 SHALL have port m_rnw, input, NUM_MASTERS bits: per-master read(1)/write(0).
REQ-010 SHALL have port m_en, input, NUM_MASTERS bits: per-master request strobe.
REQ-011 SHALL have port m_data_in, output, NUM_MASTERS*DATA_WIDTH bits: per-master read return data.
REQ-012 SHALL have port m_data_valid, output, NUM_MASTERS bits: per-master completion pulse.
REQ-013 SHALL have port m_busy, output, NUM_MASTERS bits: per-master request pending.
REQ-014 SHALL have port m_err, output, NUM_MASTERS bits: per-master timeout flag, qualified by m_data_valid.
REQ-015 SHALL have port s_address, output, ADDR_WIDTH bits: slave address.
REQ-016 SHALL have port s_data_out, output, DATA_WIDTH bits: slave write data.
REQ-017 SHALL have port s_rnw, output, 1 bit: slave read/write.
REQ-018 SHALL have port s_en, output, 1 bit: slave strobe.
REQ-019 SHALL have port s_data_in, input, DATA_WIDTH bits: slave read data.
REQ-020 SHALL have port s_data_valid, input, 1 bit: slave completion for reads and writes.

Function
REQ-021 SHALL capture address, data_out and rnw of master i into its one-deep request register on a rising edge where m_en[i]=1 and m_busy[i]=0, and set m_busy[i] from the next cycle.
REQ-022 SHALL ignore m_en[i] while m_busy[i]=1; no second request is queued.
REQ-023 SHALL use FSM states IDLE, ISSUE, WAIT.
REQ-024 IDLE: SHALL register a grant and move to ISSUE when any request is pending; otherwise remain in IDLE.
REQ-025 SHALL grant round-robin: the search starts at (last_grant+1) mod NUM_MASTERS; last_grant resets to NUM_MASTERS-1, so master 0 wins first.
REQ-026 ISSUE: SHALL hold s_en=1 for exactly one cycle, with s_address, s_data_out and s_rnw taken from the granted request register, then move to WAIT.
REQ-027 SHALL hold s_address, s_data_out and s_rnw stable from ISSUE until completion, and drive s_en=0 in every other cycle.
REQ-028 SHALL accept s_data_valid in ISSUE or WAIT. On acceptance it SHALL, on the next cycle:
  - register s_data_in into m_data_in[grant]; write transactions also update it;
  - pulse m_data_valid[grant] for one cycle with m_err[grant]=0;
  - clear m_busy[grant];
  - return to IDLE.
REQ-029 SHALL hold m_data_in[i] between completions and ignore s_data_valid in IDLE.
REQ-030 When TIMEOUT>0 and s_data_valid is absent for TIMEOUT consecutive WAIT cycles, SHALL complete the transaction as in REQ-028 with m_data_in[grant] unchanged and m_err[grant]=1.
REQ-031 SHALL give minimum latency m_en (cycle 0) -> s_en (cycle 2) -> m_data_valid (cycle 3) when the slave responds in the ISSUE cycle.
REQ-032 SHALL accept a new m_en[i] in the same cycle that master i's m_data_valid pulses, since m_busy[i] is already 0.
REQ-033 Simultaneous capture of one master and completion of another SHALL both take effect.

Reset
REQ-034 While n_rst=0, SHALL asynchronously force:
  - FSM to IDLE;
  - all request registers empty, last_grant=NUM_MASTERS-1, timeout counter 0;
  - m_busy, m_data_valid, m_err, m_data_in, s_en, s_address, s_data_out, s_rnw all 0.
REQ-035 Reset mid-transaction SHALL abandon it with no completion pulse after release.

Verification
REQ-036 Single read: master 1 reads 0x100 at cycle 0, slave returns 0xDEADBEEF in the ISSUE cycle -> s_en at cycle 2, m_data_valid[1] and m_data_in[1]=0xDEADBEEF at cycle 3, m_busy[1]=0 at cycle 3.
REQ-037 Contention: all 4 masters assert m_en in the same cycle -> grants 0,1,2,3 in order; a repeat from master 0 after its completion is served after master 3.
REQ-038 Timeout: TIMEOUT=4, slave never responds -> m_data_valid with m_err=1 after 4 WAIT cycles, m_data_in unchanged.
REQ-039 Busy rejection: master 2 pulses m_en again while busy with different data -> only the first address is seen on s_address.
REQ-040 Reset in WAIT: n_rst low for 1 cycle -> all outputs 0 immediately and no m_data_valid after release.
REQ-041 Back-to-back: master 0 re-asserts m_en in its m_data_valid cycle -> second request accepted and completed.

Source files
------------

// File: rtl/biu_arbiter.sv
// rtl/biu_arbiter.sv - round-robin arbiter sharing one slave port among NUM_MASTERS BIU masters
// Each master owns a one-deep request register; a 3-state FSM issues one transaction at a time.
module biu_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
  input  logic [NUM_MASTERS-1:0]            m_rnw,
  input  logic [NUM_MASTERS-1:0]            m_en,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_in,
  output logic [NUM_MASTERS-1:0]            m_data_valid,
  output logic [NUM_MASTERS-1:0]            m_busy,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic [DATA_WIDTH-1:0]             s_data_out,
  output logic                              s_rnw,
  output logic                              s_en,
  input  logic [DATA_WIDTH-1:0]             s_data_in,
  input  logic                              s_data_valid
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                                  state_q, state_d;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  req_data_q, req_data_d;
  logic [NUM_MASTERS-1:0]                  req_rnw_q, req_rnw_d;
  logic [NUM_MASTERS-1:0]                  busy_q, busy_d;
  logic [GW-1:0]                           grant_q, grant_d;
  logic [CW-1:0]                           cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_data_in_q, m_data_in_d;
  logic [NUM_MASTERS-1:0]                  m_data_valid_q, m_data_valid_d;
  logic [NUM_MASTERS-1:0]                  m_err_q, m_err_d;
  logic [ADDR_WIDTH-1:0]                   s_address_q, s_address_d;
  logic [DATA_WIDTH-1:0]                   s_data_out_q, s_data_out_d;
  logic                                    s_rnw_q, s_rnw_d;
  logic                                    s_en_q, s_en_d;

  logic [GW-1:0] pick_idx;
  logic [GW-1:0] cand;
  logic          pick_found;
  logic          complete;
  logic          timed_out;

  // grant_q doubles as last_grant: search begins one past the previous winner
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_q;
    cand       = grant_q;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = GW'((int'(grant_q) + k) % NUM_MASTERS);
      if (!pick_found && busy_q[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    req_rnw_d      = req_rnw_q;
    busy_d         = busy_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    m_data_in_d    = m_data_in_q;
    m_data_valid_d = '0;
    m_err_d        = '0;
    s_address_d    = s_address_q;
    s_data_out_d   = s_data_out_q;
    s_rnw_d        = s_rnw_q;
    s_en_d         = 1'b0;
    complete       = 1'b0;
    timed_out      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick_idx;
          s_address_d  = req_addr_q[pick_idx];
          s_data_out_d = req_data_q[pick_idx];
          s_rnw_d      = req_rnw_q[pick_idx];
          s_en_d       = 1'b1;
          cnt_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (s_data_valid) complete = 1'b1;
        else              state_d  = WAIT;
      end
      WAIT: begin
        if (s_data_valid) begin
          complete = 1'b1;
        end else if (TIMEOUT > 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          complete  = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      state_d                 = IDLE;
      cnt_d                   = '0;
      busy_d[grant_q]         = 1'b0;
      m_data_valid_d[grant_q] = 1'b1;
      m_err_d[grant_q]        = timed_out;
      if (!timed_out) m_data_in_d[grant_q] = s_data_in;
    end

    // A completing master is still busy this cycle, so capture and completion never collide
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (m_en[i] && !busy_q[i]) begin
        busy_d[i]     = 1'b1;
        req_addr_d[i] = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        req_data_d[i] = m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        req_rnw_d[i]  = m_rnw[i];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      req_rnw_q      <= '0;
      busy_q         <= '0;
      grant_q        <= GW'(NUM_MASTERS - 1);
      cnt_q          <= '0;
      m_data_in_q    <= '0;
      m_data_valid_q <= '0;
      m_err_q        <= '0;
      s_address_q    <= '0;
      s_data_out_q   <= '0;
      s_rnw_q        <= 1'b0;
      s_en_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      req_data_q     <= req_data_d;
      req_rnw_q      <= req_rnw_d;
      busy_q         <= busy_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      m_data_in_q    <= m_data_in_d;
      m_data_valid_q <= m_data_valid_d;
      m_err_q        <= m_err_d;
      s_address_q    <= s_address_d;
      s_data_out_q   <= s_data_out_d;
      s_rnw_q        <= s_rnw_d;
      s_en_q         <= s_en_d;
    end
  end

  assign m_data_in    = m_data_in_q;
  assign m_data_valid = m_data_valid_q;
  assign m_busy       = busy_q;
  assign m_err        = m_err_q;
  assign s_address    = s_address_q;
  assign s_data_out   = s_data_out_q;
  assign s_rnw        = s_rnw_q;
  assign s_en         = s_en_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// tb/tb_biu_arbiter.sv - directed and random checks of biu_arbiter against a transaction-level model
// The model predicts completion cycles arithmetically from the slave delay it chooses.
module tb_biu_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [N*AW-1:0] m_address;
  logic [N*DW-1:0] m_data_out;
  logic [N-1:0]    m_rnw;
  logic [N-1:0]    m_en;
  logic [N*DW-1:0] m_data_in;
  logic [N-1:0]    m_data_valid;
  logic [N-1:0]    m_busy;
  logic [N-1:0]    m_err;
  logic [AW-1:0]   s_address;
  logic [DW-1:0]   s_data_out;
  logic            s_rnw;
  logic            s_en;
  logic [DW-1:0]   s_data_in;
  logic            s_data_valid;

  biu_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .m_address(m_address), .m_data_out(m_data_out), .m_rnw(m_rnw), .m_en(m_en),
    .m_data_in(m_data_in), .m_data_valid(m_data_valid), .m_busy(m_busy), .m_err(m_err),
    .s_address(s_address), .s_data_out(s_data_out), .s_rnw(s_rnw), .s_en(s_en),
    .s_data_in(s_data_in), .s_data_valid(s_data_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // transaction-level model state
  int          cyc;
  logic [N-1:0] busy_m;
  int          inflight;
  int          last;
  int          done_cyc;
  int          resp_cyc;
  bit          exp_err;
  logic [AW-1:0] req_a [N];
  logic [DW-1:0] req_d [N];
  logic          req_r [N];
  logic [DW-1:0] mdi   [N];
  logic [DW-1:0] resp_data;
  logic [N-1:0]  exp_dv_last;

  // stimulus knobs and observation logs
  int            force_delay;
  bit            fixed_rdata_en;
  logic [DW-1:0] fixed_rdata;
  logic [AW-1:0] issued_q[$];
  int            last_en_cyc;
  int            dv_cnt [N];
  int            last_dv_cyc [N];
  logic          last_err [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] pend, input int prev);
    for (int k = 1; k <= N; k++)
      if (pend[(prev + k) % N]) return (prev + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    busy_m = '0; inflight = -1; last = N - 1; resp_cyc = -1; done_cyc = -1;
    exp_dv_last = '0;
    for (int i = 0; i < N; i++) mdi[i] = '0;
  endtask

  task automatic chk_zero();
    chk("rst_m_busy", m_busy, 0);
    chk("rst_m_data_valid", m_data_valid, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_s_en", s_en, 0);
    chk("rst_s_address", s_address, 0);
    chk("rst_s_data_out", s_data_out, 0);
    chk("rst_s_rnw", s_rnw, 0);
    for (int i = 0; i < N; i++) chk("rst_m_data_in", m_data_in[i*DW +: DW], 0);
  endtask

  // one clock: advance the model by the rules, compare, then drive the slave for the new cycle
  task automatic step();
    logic [N-1:0] bprev;
    bit           idle_prev;
    logic [N-1:0] exp_dv;
    int           w;
    int           d;
    @(posedge clk); #1;
    cyc++;
    bprev     = busy_m;
    idle_prev = (inflight < 0);
    exp_dv    = '0;
    if (inflight >= 0 && cyc == done_cyc) begin
      exp_dv[inflight] = 1'b1;
      chk("m_err", m_err[inflight], exp_err);
      if (!exp_err) mdi[inflight] = resp_data;
      busy_m[inflight] = 1'b0;
      last     = inflight;
      inflight = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && !bprev[i]) begin
        busy_m[i] = 1'b1;
        req_a[i]  = m_address[i*AW +: AW];
        req_d[i]  = m_data_out[i*DW +: DW];
        req_r[i]  = m_rnw[i];
      end
    end
    if (idle_prev && |bprev) begin
      w        = rr_pick(bprev, last);
      inflight = w;
      d        = (force_delay >= 0) ? force_delay : int'($urandom_range(0, TO + 1));
      exp_err  = (d > TO);
      done_cyc = exp_err ? cyc + TO + 1 : cyc + d + 1;
      resp_cyc = (d <= TO + 1) ? cyc + d : -1;
      chk("s_en", s_en, 1);
      chk("s_address", s_address, req_a[w]);
      chk("s_data_out", s_data_out, req_d[w]);
      chk("s_rnw", s_rnw, req_r[w]);
    end else begin
      chk("s_en_idle", s_en, 0);
    end
    chk("m_data_valid", m_data_valid, exp_dv);
    chk("m_busy", m_busy, busy_m);
    for (int i = 0; i < N; i++) chk("m_data_in", m_data_in[i*DW +: DW], mdi[i]);
    exp_dv_last = exp_dv;

    if (s_en) begin
      issued_q.push_back(s_address);
      last_en_cyc = cyc;
    end
    for (int i = 0; i < N; i++) begin
      if (m_data_valid[i]) begin
        dv_cnt[i]++;
        last_dv_cyc[i] = cyc;
        last_err[i]    = m_err[i];
      end
    end

    s_data_in    = fixed_rdata_en ? fixed_rdata : DW'($urandom);
    s_data_valid = (cyc == resp_cyc);
    if (s_data_valid) resp_data = s_data_in;
  endtask

  task automatic do_reset();
    m_en = '0; s_data_valid = 1'b0;
    n_rst = 1'b0;
    #2;
    chk_zero();
    @(posedge clk); #1;
    n_rst = 1'b1;
    model_reset();
  endtask

  logic [AW-1:0] exp_seq [5];
  logic [DW-1:0] saved;
  int            dv_before;
  int            dv0_before;
  bit            reissued;

  initial begin
    n_rst = 1'b0; m_address = '0; m_data_out = '0; m_rnw = '0; m_en = '0;
    s_data_in = '0; s_data_valid = 1'b0;
    force_delay = 0; fixed_rdata_en = 1'b0; fixed_rdata = '0;
    cyc = 0; last_en_cyc = 0; resp_data = '0;
    for (int i = 0; i < N; i++) begin dv_cnt[i] = 0; last_dv_cyc[i] = 0; last_err[i] = 1'b0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    n_rst = 1'b1;

    // single read with response in the ISSUE cycle
    cyc = 0; force_delay = 0; fixed_rdata_en = 1'b1; fixed_rdata = 32'hDEADBEEF;
    m_address[1*AW +: AW] = 32'h100; m_rnw[1] = 1'b1; m_en[1] = 1'b1;
    step(); m_en = '0;
    step();
    chk("single_s_en_cycle2", s_en, 1);
    step();
    chk("single_dv_cycle3", m_data_valid[1], 1);
    chk("single_data", m_data_in[1*DW +: DW], 32'hDEADBEEF);
    chk("single_busy_clear", m_busy[1], 0);
    fixed_rdata_en = 1'b0;
    step();

    // contention from all masters, master 0 re-requests on its completion cycle
    do_reset();
    force_delay = 1; issued_q.delete();
    dv0_before = dv_cnt[0]; reissued = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW]  = 32'h1000 + 32'(i) * 32'h100;
      m_data_out[i*DW +: DW] = DW'($urandom);
      m_rnw[i] = 1'b1;
    end
    m_en = '1;
    step(); m_en = '0;
    for (int t = 0; t < 30; t++) begin
      step();
      m_en = '0;
      if (exp_dv_last[0] && !reissued) begin
        reissued = 1'b1;
        m_en[0] = 1'b1;
        m_address[0 +: AW] = 32'h5000;
      end
    end
    exp_seq = '{32'h1000, 32'h1100, 32'h1200, 32'h1300, 32'h5000};
    chk("rr_issue_count", issued_q.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < issued_q.size()) chk("rr_order", issued_q[k], exp_seq[k]);
    chk("back_to_back_completions", dv_cnt[0] - dv0_before, 2);

    // timeout: slave never answers
    force_delay = 99; saved = mdi[3];
    m_address[3*AW +: AW] = 32'h3000; m_rnw[3] = 1'b0; m_data_out[3*DW +: DW] = 32'h1234_5678;
    m_en[3] = 1'b1;
    step(); m_en = '0;
    for (int t = 0; t < 12; t++) step();
    chk("timeout_latency", last_dv_cyc[3] - last_en_cyc, TO + 1);
    chk("timeout_err", last_err[3], 1);
    chk("timeout_data_kept", m_data_in[3*DW +: DW], saved);

    // busy rejection: second strobe while busy is dropped
    force_delay = 0; issued_q.delete();
    m_address[2*AW +: AW] = 32'h200; m_data_out[2*DW +: DW] = 32'hAAAA; m_rnw[2] = 1'b0; m_en[2] = 1'b1;
    step();
    m_address[2*AW +: AW] = 32'h2FF; m_data_out[2*DW +: DW] = 32'hBBBB;
    step(); m_en = '0;
    for (int t = 0; t < 8; t++) step();
    chk("busy_reject_count", issued_q.size(), 1);
    if (issued_q.size() > 0) chk("busy_reject_addr", issued_q[0], 32'h200);

    // reset while waiting on the slave
    force_delay = 99;
    m_address[1*AW +: AW] = 32'h4400; m_rnw[1] = 1'b1; m_en[1] = 1'b1;
    step(); m_en = '0;
    step();
    chk("wait_reset_s_en", s_en, 1);
    step();
    dv_before = dv_cnt[0] + dv_cnt[1] + dv_cnt[2] + dv_cnt[3];
    do_reset();
    for (int t = 0; t < 8; t++) step();
    chk("no_dv_after_reset", dv_cnt[0] + dv_cnt[1] + dv_cnt[2] + dv_cnt[3], dv_before);

    // randomized traffic with random slave delays including timeouts
    force_delay = -1;
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < N; i++) begin
        m_address[i*AW +: AW]  = AW'($urandom);
        m_data_out[i*DW +: DW] = DW'($urandom);
      end
      m_rnw = N'($urandom);
      m_en  = N'($urandom) & N'($urandom);
      step();
    end
    m_en = '0;
    for (int t = 0; t < 40; t++) step();
    chk("drain_idle", m_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
